// File: rtl/pipe4_if.sv
// Bus bundle for pipe4_datapath: instruction fetch, data memory and
// writeback/status observation.
interface pipe4_if #(
  parameter int DSIZE   = 16,
  parameter int PCSIZE  = 16,
  parameter int CNTSIZE = 16
);
  logic [PCSIZE-1:0]  imem_addr;
  logic [15:0]        imem_data;
  logic [DSIZE-1:0]   dmem_addr;
  logic [DSIZE-1:0]   dmem_wdata;
  logic               dmem_wen;
  logic [DSIZE-1:0]   dmem_rdata;
  logic               halted;
  logic               wb_valid;
  logic [3:0]         wb_addr;
  logic [DSIZE-1:0]   wb_data;
  logic [CNTSIZE-1:0] retired;

  modport master (
    output imem_addr, input imem_data,
    output dmem_addr, output dmem_wdata, output dmem_wen, input dmem_rdata,
    output halted, output wb_valid, output wb_addr, output wb_data, output retired
  );

  modport slave (
    input imem_addr, output imem_data,
    input dmem_addr, input dmem_wdata, input dmem_wen, output dmem_rdata,
    input halted, input wb_valid, input wb_addr, input wb_data, input retired
  );
endinterface

// File: rtl/pipe4_datapath.sv
// Four-stage (IF/ID/EX/WB) 16-bit-ISA datapath with either WB->EX forwarding
// or interlock stalling, EX-resolved branches and a terminal HALT state.
module pipe4_datapath #(
  parameter int DSIZE   = 16,
  parameter int PCSIZE  = 16,
  parameter bit FWD_EN  = 1'b1,
  parameter int CNTSIZE = 16
) (
  input  logic    clk,
  input  logic    rst,
  pipe4_if.master bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL  = 4'h6, OP_ADDI = 4'h7,
    OP_LW   = 4'h8, OP_SW   = 4'h9, OP_BEQ  = 4'hA, OP_NOPB = 4'hB,
    OP_NOPC = 4'hC, OP_NOPD = 4'hD, OP_NOPE = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  typedef struct packed {
    logic              valid;
    logic [PCSIZE-1:0] pc;
    logic [15:0]       instr;
  } if_id_t;

  typedef struct packed {
    logic              valid;
    opcode_t           op;
    logic [3:0]        rd;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [DSIZE-1:0]  rd_val;
    logic [DSIZE-1:0]  rs_val;
    logic [DSIZE-1:0]  rt_val;
    logic [DSIZE-1:0]  imm;
    logic [PCSIZE-1:0] pc;
  } id_ex_t;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [3:0]       rd;
    logic [DSIZE-1:0] data;
  } ex_wb_t;

  logic [PCSIZE-1:0]  pc;
  if_id_t             if_id;
  id_ex_t             id_ex;
  ex_wb_t             ex_wb;
  logic               halted;
  logic [CNTSIZE-1:0] retired;
  logic [DSIZE-1:0]   regs [16];

  // Writeback: r0 is hard-wired, so a write to it is not a real write.
  logic wb_we;
  assign wb_we = ex_wb.valid && ex_wb.we && (ex_wb.rd != 4'd0);

  // Decode and register read, with same-cycle bypass from WB.
  opcode_t          id_op;
  logic [3:0]       id_rd, id_rs, id_rt;
  logic [DSIZE-1:0] id_rd_val, id_rs_val, id_rt_val, id_imm;

  assign id_op  = opcode_t'(if_id.instr[15:12]);
  assign id_rd  = if_id.instr[11:8];
  assign id_rs  = if_id.instr[7:4];
  assign id_rt  = if_id.instr[3:0];
  assign id_imm = {{(DSIZE-4){if_id.instr[3]}}, if_id.instr[3:0]};

  assign id_rd_val = (id_rd == 4'd0) ? '0 : (wb_we && ex_wb.rd == id_rd) ? ex_wb.data : regs[id_rd];
  assign id_rs_val = (id_rs == 4'd0) ? '0 : (wb_we && ex_wb.rd == id_rs) ? ex_wb.data : regs[id_rs];
  assign id_rt_val = (id_rt == 4'd0) ? '0 : (wb_we && ex_wb.rd == id_rt) ? ex_wb.data : regs[id_rt];

  // Interlock: only EX can hold an unwritten result; WB is covered by the bypass.
  logic ex_writes, uses_rs, uses_rt, uses_rd, stall;
  assign ex_writes = id_ex.valid && (id_ex.op <= OP_LW) && (id_ex.rd != 4'd0);
  assign uses_rs   = (id_op <= OP_BEQ);
  assign uses_rt   = (id_op <= OP_XOR);
  assign uses_rd   = (id_op == OP_SW) || (id_op == OP_BEQ);
  assign stall     = !FWD_EN && if_id.valid && ex_writes &&
                     ((uses_rs && id_ex.rd == id_rs) ||
                      (uses_rt && id_ex.rd == id_rt) ||
                      (uses_rd && id_ex.rd == id_rd));

  // Execute, with WB->EX forwarding on every operand.
  logic [DSIZE-1:0]  ex_a, ex_b, ex_d, ex_result;
  logic              halt_ex, br_taken;
  logic [PCSIZE-1:0] br_target;

  assign ex_a = (FWD_EN && wb_we && ex_wb.rd == id_ex.rs) ? ex_wb.data : id_ex.rs_val;
  assign ex_b = (FWD_EN && wb_we && ex_wb.rd == id_ex.rt) ? ex_wb.data : id_ex.rt_val;
  assign ex_d = (FWD_EN && wb_we && ex_wb.rd == id_ex.rd) ? ex_wb.data : id_ex.rd_val;

  assign halt_ex   = id_ex.valid && (id_ex.op == OP_HALT);
  assign br_taken  = id_ex.valid && (id_ex.op == OP_BEQ) && (ex_d == ex_a);
  assign br_target = id_ex.pc + PCSIZE'(1) + {{(PCSIZE-4){id_ex.rt[3]}}, id_ex.rt};

  // NOTE: a default assignment ahead of the case keeps this block free of latches.
  always_comb begin
    ex_result = '0;
    case (id_ex.op)
      OP_ADD:  ex_result = ex_a + ex_b;
      OP_SUB:  ex_result = ex_a - ex_b;
      OP_AND:  ex_result = ex_a & ex_b;
      OP_OR:   ex_result = ex_a | ex_b;
      OP_XOR:  ex_result = ex_a ^ ex_b;
      OP_SLL:  ex_result = ex_a << id_ex.rt;
      OP_SRL:  ex_result = ex_a >> id_ex.rt;
      OP_ADDI: ex_result = ex_a + id_ex.imm;
      OP_LW:   ex_result = bus.dmem_rdata;
      default: ex_result = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of the stage ahead of it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
    end else if (halted || halt_ex) begin
      pc <= pc;
    end else if (br_taken) begin
      pc <= br_target;
    end else if (!stall) begin
      pc <= pc + PCSIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id <= '0;
    end else if (halted || halt_ex || br_taken) begin
      if_id.valid <= 1'b0;
    end else if (!stall) begin
      if_id.valid <= 1'b1;
      if_id.pc    <= pc;
      if_id.instr <= bus.imem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex <= '0;
    end else if (halted || halt_ex || br_taken || stall) begin
      id_ex.valid <= 1'b0;
    end else begin
      id_ex.valid  <= if_id.valid;
      id_ex.op     <= id_op;
      id_ex.rd     <= id_rd;
      id_ex.rs     <= id_rs;
      id_ex.rt     <= id_rt;
      id_ex.rd_val <= id_rd_val;
      id_ex.rs_val <= id_rs_val;
      id_ex.rt_val <= id_rt_val;
      id_ex.imm    <= id_imm;
      id_ex.pc     <= if_id.pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_wb   <= '0;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      ex_wb.valid <= id_ex.valid;
      ex_wb.we    <= (id_ex.op <= OP_LW);
      ex_wb.rd    <= id_ex.rd;
      ex_wb.data  <= ex_result;
      if (halt_ex) halted <= 1'b1;
      if (ex_wb.valid) retired <= retired + CNTSIZE'(1);
    end
  end

  // NOTE: the register file is reset explicitly because software may rely on
  // every register reading 0 after reset, not only r0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[ex_wb.rd] <= ex_wb.data;
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = ex_a + id_ex.imm;
  assign bus.dmem_wdata = ex_d;
  assign bus.dmem_wen   = id_ex.valid && (id_ex.op == OP_SW) && !halted;
  assign bus.halted     = halted;
  assign bus.wb_valid   = wb_we;
  assign bus.wb_addr    = ex_wb.rd;
  assign bus.wb_data    = ex_wb.data;
  assign bus.retired    = retired;

endmodule

// File: doc/pipe4_datapath.md
Name: pipe4_datapath

Overview:
- Four-stage pipelined generalisation of the team's single-cycle 16-bit datapath: IF, ID, EX, WB.
- Parametrised data and PC width.
- Selectable hazard mode: forwarding, or interlock stalling.
- Branch flush and a HALT state.
- Instruction and data memories are external, with asynchronous read. This block contains the PC, regfile, ALU, control and pipeline registers.

Parameters:
- DSIZE, 16, datapath/register width (>=8).
- PCSIZE, 16, PC and instruction-memory address width.
- FWD_EN, 1: 1 = WB->EX forwarding, no RAW stalls; 0 = interlock with stall bubbles.
- CNTSIZE, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- imem_addr  out  PCSIZE  current PC.
- imem_data  in  16  instruction at imem_addr, same cycle.
- dmem_addr  out  DSIZE  EX-stage address rs+sext(imm).
- dmem_wdata  out  DSIZE  EX-stage store data (forwarded rd value).
- dmem_wen  out  1  store strobe, EX stage.
- dmem_rdata  in  DSIZE  load data for dmem_addr, same cycle.
- halted  out  1  HALT has reached EX; core frozen.
- wb_valid  out  1  WB stage holds a register write this cycle.
- wb_addr  out  4  WB destination register.
- wb_data  out  DSIZE  WB write data.
- retired  out  CNTSIZE  count of instructions that completed WB, including stores and branches.

Behaviour:
- Instruction format: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm. imm is sign-extended to DSIZE.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: rd <= rs op rt.
  - 5 SLL, 6 SRL: rd <= rs shifted by imm[3:0] as unsigned.
  - 7 ADDI: rd <= rs + imm.
  - 8 LW: rd <= M[rs+imm].
  - 9 SW: M[rs+imm] <= rd.
  - A BEQ: if rd==rs, PC <= PC_br+1+imm.
  - F HALT.
  - B-E are NOP.
- Arithmetic is modulo 2^DSIZE. PC arithmetic is modulo 2^PCSIZE and wraps.
- Regfile: 16 x DSIZE. r0 reads 0, and writes to r0 are discarded (wb_valid still 0 for them). A write in WB to a register read in ID the same cycle returns the new value (internal bypass).
- Pipeline registers: IF_ID, ID_EX, EX_WB, each with a valid bit. Invalid entries are bubbles: no write, no store, not counted.
- Latency: an instruction fetched at cycle n writes back at the n+3 edge. retired increments on the same edge as its WB completes.
- Forwarding, FWD_EN=1: an EX operand equal to the EX_WB destination (valid, nonzero) takes the EX_WB data. No stalls ever.
- Interlock, FWD_EN=0: ID stalls while valid ID_EX writes a nonzero register matching ID's rs, rt (R-type) or rd (SW/BEQ). During a stall, PC and IF_ID hold and ID_EX receives a bubble. Expected stall is 1 cycle.
- Branch: resolved in EX. If taken, PC <= target, and IF_ID and ID_EX are invalidated (2-cycle penalty). If not taken there is no penalty.
- Branch vs stall: a taken branch in EX overrides a simultaneous stall.
- HALT: when a valid HALT is in EX:
  - halted <= 1, and IF_ID/ID_EX are invalidated;
  - PC freezes;
  - the instruction ahead in WB completes;
  - HALT itself counts as retired;
  - afterwards the pipeline stays empty until reset.
- dmem_wen = 1 only for a valid SW in EX and never while halted.
- Reset (asynchronous, any time, including mid-branch or mid-stall): PC=0, all valid bits 0, regfile all 0, halted=0, retired=0, wb_valid=0, wb_addr=0, wb_data=0, dmem_wen=0. The first fetch of address 0 occurs in the first cycle after deassertion.
- retired wraps at 2^CNTSIZE.

Test Plan:
- Reset then ADDI r1,r0,5 / ADDI r2,r0,-3 / ADD r3,r1,r2 back-to-back, with FWD_EN=1 -> wb shows r1=5, r2=0xFFFD, r3=2; no bubbles; retired=3 after 6 cycles.
- Same program with FWD_EN=0 -> identical results; one bubble before ADD (wb_valid gap); r3 writes back 1 cycle later.
- SW r1,[r0+4] then LW r4,[r0+4], with a memory model -> dmem_wen pulse with addr 4, data 5; r4=5 at WB.
- BEQ r1,r1,+2 at PC=3 -> PC becomes 6; the instructions at 4 and 5 never write back. BEQ with unequal operands -> sequential fetch, no bubbles.
- HALT at PC=2 after two ADDIs -> halted=1 is raised, imem_addr stays frozen, both ADDIs retire, retired=3, no later dmem_wen.
- Assert rst low mid-stall and mid-branch -> all outputs return to reset values immediately; execution restarts at PC=0 after release.
